// File: rtl/tx_byte_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tx_byte_arbiter
// Description : Packet-atomic round-robin arbiter that shares one serial TX
//               byte channel between NUM_REQ packet sources. A granted source
//               keeps the channel until the byte flagged last has been issued.
//               A guard window after each issued byte masks tx_busy_i latency,
//               and a stall timeout drops a source that stops mid-packet.
// Ports       : clk_i        - system clock
//               rst_i        - synchronous active-high reset
//               req_valid_i  - per-source byte valid
//               req_data_i   - per-source byte, source k at [8k+7:8k]
//               req_last_i   - per-source last-byte-of-packet flag
//               req_ack_o    - one-cycle pulse, source byte consumed
//               tx_busy_i    - serial transmitter busy
//               tx_new_o     - one-cycle pulse, tx_data_o valid
//               tx_data_o    - byte to transmit
//               grant_o      - one-hot current grant, zero when idle
//               abort_o      - one-cycle pulse, granted packet timed out
// Revision    : 1.0 - initial release
// ============================================================================
module tx_byte_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int GUARD_CYCLES = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ack_o,
    input  logic                   tx_busy_i,
    output logic                   tx_new_o,
    output logic [7:0]             tx_data_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   abort_o
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_GD_W  = $clog2(GUARD_CYCLES + 1);
    localparam int c_TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [c_IDX_W-1:0] c_PTR_RST    = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_GD_W-1:0]  c_GUARD_LAST = c_GD_W'(GUARD_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LIMIT   = c_TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [c_IDX_W-1:0]   r_ptr;        // index of the last source served
    logic [c_IDX_W-1:0]   r_gidx;       // index of the granted source
    logic                 r_last;       // issued byte closed the packet
    logic [c_GD_W-1:0]    r_guard_cnt;
    logic [c_TO_W-1:0]    r_to_cnt;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_tx_new;
    logic [7:0]           r_tx_data;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_abort;

    // Next-state values
    state_t               w_state;
    logic [c_IDX_W-1:0]   w_ptr;
    logic [c_IDX_W-1:0]   w_gidx;
    logic                 w_last;
    logic [c_GD_W-1:0]    w_guard_cnt;
    logic [c_TO_W-1:0]    w_to_cnt;
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_tx_new;
    logic [7:0]           w_tx_data;
    logic [NUM_REQ-1:0]   w_ack;
    logic                 w_abort;

    // Arbitration and granted-source views
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_pick;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [7:0]           w_sel_data;
    logic                 w_to_hit;

    // (p + i) modulo NUM_REQ for 1 <= i <= NUM_REQ; one subtraction suffices.
    function automatic logic [c_IDX_W-1:0] wrap_add(input logic [c_IDX_W-1:0] p,
                                                    input int i);
        int s;
        s = int'(p) + i;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return c_IDX_W'(s);
    endfunction

    // Round-robin search: first valid source strictly after the last one
    // served, wrapping, so the last-served source has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_found && req_valid_i[wrap_add(r_ptr, i)]) begin
                w_found = 1'b1;
                w_pick  = wrap_add(r_ptr, i);
            end
        end
    end

    assign w_sel_valid = req_valid_i[r_gidx];
    assign w_sel_last  = req_last_i[r_gidx];
    assign w_sel_data  = req_data_i[{r_gidx, 3'b000} +: 8];

    // Checked before the valid input so a timeout beats a late-arriving byte.
    assign w_to_hit = (TIMEOUT != 0) && (r_to_cnt == c_TO_LIMIT);

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state     = r_state;
        w_ptr       = r_ptr;
        w_gidx      = r_gidx;
        w_last      = r_last;
        w_guard_cnt = r_guard_cnt;
        w_to_cnt    = r_to_cnt;
        w_grant     = r_grant;
        w_tx_new    = 1'b0;
        w_tx_data   = r_tx_data;
        w_ack       = '0;
        w_abort     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gidx          = w_pick;
                    w_grant         = '0;
                    w_grant[w_pick] = 1'b1;
                    w_to_cnt        = '0;
                    w_state         = S_SEND;
                end
            end

            S_SEND: begin
                if (w_to_hit) begin
                    // Bytes already issued stay issued; only the grant is lost.
                    w_abort  = 1'b1;
                    w_grant  = '0;
                    w_ptr    = r_gidx;
                    w_to_cnt = '0;
                    w_state  = S_IDLE;
                end else if (w_sel_valid && !tx_busy_i) begin
                    w_tx_new      = 1'b1;
                    w_tx_data     = w_sel_data;
                    w_ack[r_gidx] = 1'b1;
                    w_last        = w_sel_last;
                    w_to_cnt      = '0;
                    w_guard_cnt   = '0;
                    w_state       = S_GUARD;
                end else if (!w_sel_valid && (TIMEOUT != 0)) begin
                    // Only a missing byte counts as a stall; a busy
                    // transmitter is not the source's fault.
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end

            S_GUARD: begin
                // First guard cycle is the one in which tx_new_o is high.
                if (r_guard_cnt == c_GUARD_LAST) begin
                    if (r_last) begin
                        w_ptr   = r_gidx;
                        w_grant = '0;
                        w_state = S_IDLE;
                    end else begin
                        w_state = S_SEND;
                    end
                end else begin
                    w_guard_cnt = r_guard_cnt + 1'b1;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_ptr       <= c_PTR_RST;
            r_gidx      <= '0;
            r_last      <= 1'b0;
            r_guard_cnt <= '0;
            r_to_cnt    <= '0;
            r_grant     <= '0;
            r_tx_new    <= 1'b0;
            r_tx_data   <= 8'h00;
            r_ack       <= '0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ptr       <= w_ptr;
            r_gidx      <= w_gidx;
            r_last      <= w_last;
            r_guard_cnt <= w_guard_cnt;
            r_to_cnt    <= w_to_cnt;
            r_grant     <= w_grant;
            r_tx_new    <= w_tx_new;
            r_tx_data   <= w_tx_data;
            r_ack       <= w_ack;
            r_abort     <= w_abort;
        end
    end

    assign req_ack_o = r_ack;
    assign tx_new_o  = r_tx_new;
    assign tx_data_o = r_tx_data;
    assign grant_o   = r_grant;
    assign abort_o   = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_tx_byte_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_byte_arbiter
// Description : Self-checking bench for tx_byte_arbiter with two queue-driven
//               packet sources, a behavioural reference model compared every
//               cycle, and hand-computed byte order / timing expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_byte_arbiter;

    localparam int N  = 2;
    localparam int G  = 2;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_valid_i;
    logic [8*N-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ack_o;
    logic           tx_busy_i;
    logic           tx_new_o;
    logic [7:0]     tx_data_o;
    logic [N-1:0]   grant_o;
    logic           abort_o;

    always #5 clk = ~clk;

    tx_byte_arbiter #(
        .NUM_REQ      (N),
        .GUARD_CYCLES (G),
        .TIMEOUT      (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ack_o   (req_ack_o),
        .tx_busy_i   (tx_busy_i),
        .tx_new_o    (tx_new_o),
        .tx_data_o   (tx_data_o),
        .grant_o     (grant_o),
        .abort_o     (abort_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Sources: each queue entry is {last, data}; head is presented while the
    // queue is non-empty and popped when the arbiter acknowledges it.
    // ------------------------------------------------------------------------
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit  busy_mode  = 1'b0;
    int  busy_start = -100;
    int  last_busy  = -100;

    always @(negedge clk) begin
        #1;
        if (!rst_i) begin
            if (req_ack_o[0] && q0.size() > 0) void'(q0.pop_front());
            if (req_ack_o[1] && q1.size() > 0) void'(q1.pop_front());
        end
        req_valid_i[0]   = (q0.size() > 0);
        req_data_i[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        req_last_i[0]    = (q0.size() > 0) ? q0[0][8]   : 1'b0;
        req_valid_i[1]   = (q1.size() > 0);
        req_data_i[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        req_last_i[1]    = (q1.size() > 0) ? q1[0][8]   : 1'b0;
        // Busy rises two cycles after each issued byte and stays up 20 cycles.
        if (busy_mode && tx_new_o) busy_start = cyc + 2;
        tx_busy_i = busy_mode && (cyc >= busy_start) && (cyc < busy_start + 20);
        if (tx_busy_i) last_busy = cyc;
    end

    task automatic push(input int src, input logic [7:0] d, input logic l);
        if (src == 0) q0.push_back({l, d});
        else          q1.push_back({l, d});
    endtask

    // ------------------------------------------------------------------------
    // Reference model: owner of the channel, remaining guard cycles, stall
    // count; expected registered outputs for the following cycle.
    // ------------------------------------------------------------------------
    int         m_owner = -1;
    int         m_rr    = N - 1;
    int         m_guard = 0;
    int         m_stall = 0;
    bit         m_end   = 1'b0;
    logic       e_new, e_abort;
    logic [7:0] e_data;
    logic [N-1:0] e_ack, e_grant;

    task automatic model_step();
        e_new   = 1'b0;
        e_abort = 1'b0;
        e_ack   = '0;
        if (rst_i) begin
            m_owner = -1; m_rr = N - 1; m_guard = 0; m_stall = 0; m_end = 1'b0;
            e_data  = 8'h00;
            e_grant = '0;
        end else if (m_owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                if (m_owner < 0 && req_valid_i[(m_rr + i) % N]) m_owner = (m_rr + i) % N;
            end
            if (m_owner >= 0) begin
                e_grant = '0;
                e_grant[m_owner] = 1'b1;
                m_stall = 0;
            end
        end else if (m_guard > 0) begin
            m_guard--;
            if (m_guard == 0 && m_end) begin
                m_rr = m_owner; m_owner = -1; e_grant = '0;
            end
        end else if (m_stall == TO) begin
            e_abort = 1'b1;
            m_rr = m_owner; m_owner = -1; e_grant = '0; m_stall = 0;
        end else if (req_valid_i[m_owner] && !tx_busy_i) begin
            e_new  = 1'b1;
            e_data = req_data_i[8*m_owner +: 8];
            e_ack[m_owner] = 1'b1;
            m_end   = req_last_i[m_owner];
            m_stall = 0;
            m_guard = G;
        end else if (!req_valid_i[m_owner]) begin
            m_stall++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare and event logs
    // ------------------------------------------------------------------------
    logic [7:0]   txd[$];
    int           txc[$];
    logic [N-1:0] grl[$];
    int           abc[$];
    logic [N-1:0] prev_grant = '0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cycle {new,ack,grant,abort}", {26'd0, tx_new_o, req_ack_o, grant_o, abort_o},
                {26'd0, e_new, e_ack, e_grant, e_abort});
            if (e_new) chk("tx_data", {24'd0, tx_data_o}, {24'd0, e_data});
        end
        if (tx_new_o === 1'b1) begin
            txd.push_back(tx_data_o);
            txc.push_back(cyc);
        end
        if (abort_o === 1'b1) abc.push_back(cyc);
        if (grant_o != '0 && prev_grant == '0) grl.push_back(grant_o);
        prev_grant = grant_o;
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    logic [7:0]   exq[$];
    logic [N-1:0] exg[$];

    task automatic clear_logs();
        txd.delete(); txc.delete(); grl.delete(); abc.delete();
    endtask

    task automatic chk_bytes(input string nm);
        logic [7:0] a;
        chk({nm, "_count"}, txd.size(), exq.size());
        for (int i = 0; i < exq.size(); i++) begin
            a = (i < txd.size()) ? txd[i] : 8'hxx;
            chk(nm, {24'd0, a}, {24'd0, exq[i]});
        end
    endtask

    task automatic chk_grants(input string nm);
        logic [N-1:0] a;
        chk({nm, "_count"}, grl.size(), exg.size());
        for (int i = 0; i < exg.size(); i++) begin
            a = (i < grl.size()) ? grl[i] : 'x;
            chk(nm, {30'd0, a}, {30'd0, exg[i]});
        end
    endtask

    task automatic wait_quiet(input int budget, input string nm);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || grant_o != '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_in_budget"}, (n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int n;
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        tx_busy_i   = 1'b0;

        @(negedge clk);
        chk("reset tx_new",  tx_new_o,  0);
        chk("reset tx_data", tx_data_o, 0);
        chk("reset ack",     req_ack_o, 0);
        chk("reset grant",   grant_o,   0);
        chk("reset abort",   abort_o,   0);
        rst_i  = 1'b0;
        chk_en = 1'b1;

        // Two sources valid from reset: packets stay whole, then round robin.
        clear_logs();
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
        push(0, 8'h30, 1'b0); push(0, 8'h31, 1'b1);
        push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
        wait_quiet(200, "t2");
        exq = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};
        chk_bytes("t2_order");
        exg = '{2'b01, 2'b10, 2'b01};
        chk_grants("t2_grants");

        // Single source, 3-byte packet, idle transmitter.
        clear_logs();
        push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
        wait_quiet(100, "t1");
        exq = '{8'hA1, 8'hA2, 8'hA3};
        chk_bytes("t1_bytes");
        chk("t1_spacing01", txc.size() > 1 ? txc[1] - txc[0] : -1, 3);
        chk("t1_spacing12", txc.size() > 2 ? txc[2] - txc[1] : -1, 3);
        exg = '{2'b01};
        chk_grants("t1_grants");

        // Continuous 1-byte packets from both sources alternate (source 0 was
        // served last, so source 1 leads).
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            push(0, 8'h40 + 8'(i), 1'b1);
            push(1, 8'h50 + 8'(i), 1'b1);
        end
        wait_quiet(200, "t3");
        exq = '{8'h50, 8'h40, 8'h51, 8'h41, 8'h52, 8'h42, 8'h53, 8'h43};
        chk_bytes("t3_order");
        exg = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        chk_grants("t3_grants");

        // Transmitter busy for 20 cycles starting 2 cycles after each byte:
        // issue at c, busy c+2..c+21, next issue visible at c+23.
        clear_logs();
        busy_mode = 1'b1;
        push(0, 8'h60, 1'b0); push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b1);
        wait_quiet(300, "t4");
        busy_mode = 1'b0;
        repeat (25) @(negedge clk);
        exq = '{8'h60, 8'h61, 8'h62};
        chk_bytes("t4_bytes");
        chk("t4_spacing01", txc.size() > 1 ? txc[1] - txc[0] : -1, 23);
        chk("t4_spacing12", txc.size() > 2 ? txc[2] - txc[1] : -1, 23);

        // Stall timeout: byte issued at c, guard c..c+1, 16 stalled SEND
        // cycles c+2..c+17, abort decided in c+18 and visible at c+19.
        clear_logs();
        push(0, 8'h70, 1'b0);
        n = 0;
        while (grant_o != 2'b01 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_first_grant", grant_o, 2'b01);
        push(1, 8'h80, 1'b1);
        wait_quiet(200, "t5");
        exq = '{8'h70, 8'h80};
        chk_bytes("t5_bytes");
        chk("t5_abort_count", abc.size(), 1);
        chk("t5_abort_delay", (abc.size() > 0 && txc.size() > 0) ? abc[0] - txc[0] : -1, 19);
        exg = '{2'b01, 2'b10};
        chk_grants("t5_grants");

        // Reset mid-packet after byte 2 of 4; source 0 served last beforehand,
        // so only the pointer reset lets source 0 win afterwards.
        push(0, 8'h90, 1'b1);
        wait_quiet(100, "t6a");
        clear_logs();
        push(0, 8'h91, 1'b0); push(0, 8'h92, 1'b0);
        push(0, 8'h93, 1'b0); push(0, 8'h94, 1'b1);
        n = 0;
        while (txd.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk("t6_two_bytes_seen", (txd.size() >= 2), 1);
        rst_i = 1'b1;
        q0.delete();
        q1.delete();
        req_valid_i = '0;
        @(negedge clk);
        chk("t6_rst tx_new",  tx_new_o,  0);
        chk("t6_rst tx_data", tx_data_o, 0);
        chk("t6_rst ack",     req_ack_o, 0);
        chk("t6_rst grant",   grant_o,   0);
        chk("t6_rst abort",   abort_o,   0);
        rst_i = 1'b0;
        clear_logs();
        push(0, 8'hC0, 1'b1);
        push(1, 8'hD0, 1'b1);
        wait_quiet(100, "t6b");
        exq = '{8'hC0, 8'hD0};
        chk_bytes("t6_after_reset");
        exg = '{2'b01, 2'b10};
        chk_grants("t6_grants");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
